// File: rtl/program_loader_pkg.sv
// Shared types and frame-format constants for the program RAM loader.
package program_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [7:0] START_DEFAULT = 8'hA5;
   localparam logic [7:0] LEN_MIN       = 8'd1;

endpackage

// File: rtl/program_loader.sv
// Framed byte-stream loader for the CPU program RAM; holds the CPU in reset until commit.
// Optional inter-byte timeout enabled by defining PROGRAM_LOADER_TIMEOUT_EN.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int         ADDR_W         = 4,
   parameter logic [7:0] START_BYTE     = START_DEFAULT,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              load_ram,
   output logic [ADDR_W-1:0] load_addr,
   output logic [7:0]        load_data,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int DEPTH = 1 << ADDR_W;

   state_t            state, state_n;
   logic              rdy;
   logic [8:0]        cnt;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        sum;
   logic              acc;
   logic              len_bad;
   logic              in_frame;

   assign acc      = in_valid && rdy;
   assign len_bad  = (in_data < LEN_MIN) || (32'(in_data) > 32'(DEPTH));
   assign in_frame = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);

   assign in_ready  = rdy;
   assign busy      = in_frame;
   assign done      = (state == S_DONE);
   assign error     = (state == S_ERR);
   assign cpu_reset = (state == S_DONE);

`ifdef PROGRAM_LOADER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo;
   logic             tmo_hit;

   assign tmo_hit = in_frame && !acc && (tmo == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)              tmo <= '0;
      else if (!in_frame || acc) tmo <= '0;
      else                     tmo <= tmo + 1'b1;
   end
`else
   logic        tmo_hit;
   logic [31:0] unused_tmo;
   assign tmo_hit    = 1'b0;
   assign unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE, S_DONE, S_ERR:
            if (acc && in_data == START_BYTE) state_n = S_LEN;
         S_LEN:
            if (acc) state_n = len_bad ? S_ERR : S_DATA;
         S_DATA:
            if (acc && cnt == 9'd1) state_n = S_CSUM;
         S_CSUM:
            if (acc) state_n = (in_data == sum) ? S_DONE : S_ERR;
         default:
            state_n = S_IDLE;
      endcase
      if (tmo_hit) state_n = S_ERR;
   end

   // Strobe is registered so RAM sees a clean one-cycle write after acceptance.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdy       <= 1'b0;
         cnt       <= '0;
         addr      <= '0;
         sum       <= '0;
         load_ram  <= 1'b0;
         load_addr <= '0;
         load_data <= '0;
      end else begin
         rdy      <= 1'b1;
         load_ram <= 1'b0;
         if (state == S_LEN && acc) begin
            cnt  <= {1'b0, in_data};
            addr <= '0;
            sum  <= '0;
         end
         if (state == S_DATA && acc) begin
            load_ram  <= 1'b1;
            load_addr <= addr;
            load_data <= in_data;
            addr      <= addr + 1'b1;
            sum       <= sum + in_data;
            cnt       <= cnt - 9'd1;
         end
      end
   end

endmodule
